// File: rtl/rr_grant_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
// Search helpers work on a 64-bit request view (max N_REQ).
package rr_grant_pkg;

  localparam int MAX_REQ = 64;
  localparam int MAX_W   = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [MAX_W-1:0] idx;
  } pick_t;

  // Modulo-n increment of an index.
  function automatic logic [MAX_W-1:0] next_idx(
    input logic [MAX_W-1:0] idx,
    input int               n
  );
    if (int'(idx) + 1 >= n) return '0;
    return idx + 1'b1;
  endfunction

  // First set request at or after ptr, wrapping at n-1 to 0.
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [MAX_W-1:0]   ptr,
    input int                 n
  );
    pick_t p;
    int    c;
    p = '0;
    c = 0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n && !p.found) begin
        c = int'(ptr) + k;
        if (c >= n) c = c - n;
        if (req[c[MAX_W-1:0]]) begin
          p.found = 1'b1;
          p.idx   = c[MAX_W-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_onehot_decode.sv
// Binary index to one-hot vector decoder.
// Indices beyond OUT_WIDTH-1 shift out to all-zero.
module onehot_decode #(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_WIDTH = 8
) (
  input  logic [IN_WIDTH-1:0]  i_idx,
  output logic [OUT_WIDTH-1:0] o_onehot
);

  // Shift a single set bit into position.
  always_comb begin
    o_onehot = OUT_WIDTH'(1) << i_idx;
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: hold grant until done, no preemption.
// Optional checks/grant counters with macro RR_GRANT_CHECK_EN.
module rr_grant_scheduler
  import rr_grant_pkg::*;
#(
  parameter  int N_REQ = 8,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             busy
);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;

  logic [MAX_REQ-1:0] w_req;
  logic [MAX_REQ-1:0] w_excl;
  logic [MAX_W-1:0]   w_nptr;
  pick_t              w_pick;
  pick_t              w_repick;
  logic [N_REQ-1:0]   w_dec;
  logic               w_unused;

  // Arbitration from ptr, and same-cycle re-arbitration on release.
  always_comb begin
    w_req    = MAX_REQ'(req);
    w_pick   = rr_pick(w_req, MAX_W'(r_ptr), N_REQ);
    w_nptr   = next_idx(MAX_W'(r_idx), N_REQ);
    w_excl   = w_req & ~(MAX_REQ'(1) << r_idx);
    w_repick = rr_pick(w_excl, w_nptr, N_REQ);
  end

  assign w_unused = ^{w_pick.idx, w_repick.idx, w_nptr};

  // Two-state grant FSM with registered index and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick.found) begin
            r_state <= GRANT;
            r_idx   <= w_pick.idx[IDX_W-1:0];
            r_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (done) begin
            r_ptr <= w_nptr[IDX_W-1:0];
            if (w_repick.found) begin
              r_idx <= w_repick.idx[IDX_W-1:0];
            end else begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  onehot_decode #(
    .IN_WIDTH (IDX_W),
    .OUT_WIDTH(N_REQ)
  ) u_dec (
    .i_idx   (r_idx),
    .o_onehot(w_dec)
  );

  assign gnt       = w_dec & {N_REQ{r_valid}};
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign busy      = (r_state == GRANT);

`ifdef RR_GRANT_CHECK_EN
  logic [31:0] r_gnt_cnt [N_REQ];
  logic        w_new;
  logic [IDX_W-1:0] w_new_idx;

  always_comb begin
    w_new     = 1'b0;
    w_new_idx = '0;
    if (r_state == IDLE && w_pick.found) begin
      w_new     = 1'b1;
      w_new_idx = w_pick.idx[IDX_W-1:0];
    end else if (r_state == GRANT && done && w_repick.found) begin
      w_new     = 1'b1;
      w_new_idx = w_repick.idx[IDX_W-1:0];
    end
  end

  // Per-requester count of grants issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) r_gnt_cnt[i] <= '0;
    end else if (w_new) begin
      r_gnt_cnt[w_new_idx] <= r_gnt_cnt[w_new_idx] + 32'd1;
    end
  end

  // Grant shape and protocol checks.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(gnt))
        else $error("gnt not onehot0");
      if (gnt_valid) begin
        assert ($onehot(gnt) && int'(gnt_idx) < N_REQ)
          else $error("bad grant while valid");
      end
      assert (!(done && !gnt_valid))
        else $warning("done while idle");
    end
  end
`endif

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler (N_REQ=8 and N_REQ=5).
// Vector table plus hand sequences for wrap, reset and no-bubble.
module tb_rr_grant_scheduler;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       busy;

  logic [4:0] req5;
  logic       done5;
  logic [4:0] gnt5;
  logic [2:0] idx5;
  logic       vld5;
  logic       busy5;

  int n_pass;
  int n_tot;

  rr_grant_scheduler #(.N_REQ(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .busy     (busy)
  );

  rr_grant_scheduler #(.N_REQ(5)) u_dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req5),
    .done     (done5),
    .gnt      (gnt5),
    .gnt_idx  (idx5),
    .gnt_valid(vld5),
    .busy     (busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    req5  = '0;
    done5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string nm, input logic [7:0] eg,
                         input logic [2:0] ei, input logic ev);
    chk({nm, ".gnt"}, 64'(gnt), 64'(eg));
    chk({nm, ".vld"}, 64'(gnt_valid), 64'(ev));
    chk({nm, ".busy"}, 64'(busy), 64'(ev));
    if (ev) chk({nm, ".idx"}, 64'(gnt_idx), 64'(ei));
  endtask

  initial begin
    int e;
    n_pass = 0;
    n_tot  = 0;
    rst_n  = 1'b0;
    req    = '0;
    done   = 1'b0;
    req5   = '0;
    done5  = 1'b0;

    tbl[0]  = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[1]  = '{8'h00, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[2]  = '{8'h00, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[3]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[4]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[5]  = '{8'h03, 1'b0, 8'h01, 3'd0, 1'b1};
    tbl[6]  = '{8'h03, 1'b1, 8'h02, 3'd1, 1'b1};
    tbl[7]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[8]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[9]  = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1};
    tbl[10] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[11] = '{8'h03, 1'b0, 8'h01, 3'd0, 1'b1};
    tbl[12] = '{8'h03, 1'b1, 8'h02, 3'd1, 1'b1};
    tbl[13] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[14] = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1};
    tbl[15] = '{8'h01, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[16] = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1};
    tbl[17] = '{8'h81, 1'b1, 8'h80, 3'd7, 1'b1};
    tbl[18] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[19] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};

    // Reset values
    do_reset();
    chk("rst.gnt", 64'(gnt), 64'h0);
    chk("rst.idx", 64'(gnt_idx), 64'h0);
    chk("rst.vld", 64'(gnt_valid), 64'h0);
    chk("rst.busy", 64'(busy), 64'h0);

    // Vector table
    for (int i = 0; i < 20; i++) begin
      req  = tbl[i].req;
      done = tbl[i].done;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx,
              tbl[i].vld);
    end

    // All requesting, done every third cycle: no idle bubble
    do_reset();
    req = 8'hFF;
    step();
    chk_out("ff.first", 8'h01, 3'd0, 1'b1);
    for (int g = 1; g <= 8; g++) begin
      e = g % 8;
      done = 1'b0;
      step();
      chk_out($sformatf("ff.hold%0d", g), 8'(1 << ((g - 1) % 8)),
              3'((g - 1) % 8), 1'b1);
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      chk_out($sformatf("ff.next%0d", g), 8'(1 << e), 3'(e), 1'b1);
    end

    // Asynchronous reset mid-grant
    do_reset();
    req = 8'h08;
    step();
    chk_out("mid.g3", 8'h08, 3'd3, 1'b1);
    req = 8'h00;
    step();
    chk_out("mid.hold", 8'h08, 3'd3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.async.gnt", 64'(gnt), 64'h0);
    chk("mid.async.idx", 64'(gnt_idx), 64'h0);
    chk("mid.async.vld", 64'(gnt_valid), 64'h0);
    chk("mid.async.busy", 64'(busy), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 8'hFF;
    step();
    chk_out("mid.after", 8'h01, 3'd0, 1'b1);
    req  = 8'h00;
    done = 1'b1;
    step();
    done = 1'b0;
    chk_out("mid.idle", 8'h00, 3'd0, 1'b0);

    // N_REQ=5 wrap
    req5 = 5'h1F;
    step();
    chk("n5.first.idx", 64'(idx5), 64'd0);
    chk("n5.first.gnt", 64'(gnt5), 64'h01);
    for (int k = 1; k <= 6; k++) begin
      done5 = 1'b1;
      step();
      chk($sformatf("n5.idx%0d", k), 64'(idx5), 64'(k % 5));
      chk($sformatf("n5.gnt%0d", k), 64'(gnt5), 64'(1 << (k % 5)));
      chk($sformatf("n5.vld%0d", k), 64'(vld5), 64'd1);
    end
    req5  = 5'h00;
    done5 = 1'b1;
    step();
    done5 = 1'b0;
    chk("n5.idle.gnt", 64'(gnt5), 64'h0);
    chk("n5.idle.vld", 64'(vld5), 64'h0);
    chk("n5.idle.busy", 64'(busy5), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
